// File: rtl/audio_pwm_sink.sv
// Audio sample sink: small FIFO feeding an 8-bit, 256-cycle-frame PWM generator.
// Optional underrun statistics counter enabled by defining AUDIO_PWM_SINK_STATS_EN.
module audio_pwm_sink #(
    parameter int FIFO_DEPTH    = 4,
    parameter bit UNDERRUN_HOLD = 1'b1
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_sample_valid,
    input  logic [8:0]                    i_sample,
    output logic                          o_pwm,
    output logic [7:0]                    o_level,
    output logic                          o_frame_start,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
    output logic                          o_overflow,
    output logic                          o_underrun,
    output logic [7:0]                    o_underrun_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    // Clamp a 9-bit sample into the 8-bit duty range.
    function automatic logic [7:0] saturate9(input logic [8:0] s);
        saturate9 = s[8] ? 8'hFF : s[7:0];
    endfunction

    logic [7:0]    phase_r;
    logic          started_r;
    logic [7:0]    fifo_mem_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [7:0]    level_r;
    logic          pwm_r;
    logic          frame_start_r;
    logic          overflow_r;
    logic          underrun_r;

    logic [7:0]    phase_next_s;
    logic          pop_cycle_s;
    logic          pop_ok_s;
    logic          underrun_ev_s;
    logic          push_ok_s;
    logic          overflow_ev_s;
    logic [CW-1:0] count_after_pop_s;
    logic [CW-1:0] count_next_s;
    logic [7:0]    level_next_s;

    // Next-state decode: pop is resolved before push so a full FIFO can accept in the pop cycle.
    always_comb begin
        phase_next_s      = 8'd0;
        pop_cycle_s       = 1'b0;
        pop_ok_s          = 1'b0;
        underrun_ev_s     = 1'b0;
        push_ok_s         = 1'b0;
        overflow_ev_s     = 1'b0;
        count_after_pop_s = count_r;
        count_next_s      = count_r;
        level_next_s      = level_r;

        // The first cycle after reset release is held at phase 0 to open a clean frame.
        if (started_r) begin
            phase_next_s = phase_r + 8'd1;
        end else begin
            phase_next_s = 8'd0;
        end

        pop_cycle_s   = started_r && (phase_r == 8'd255);
        pop_ok_s      = pop_cycle_s && (count_r != {CW{1'b0}});
        underrun_ev_s = pop_cycle_s && (count_r == {CW{1'b0}});

        count_after_pop_s = count_r - {{(CW-1){1'b0}}, pop_ok_s};
        if (i_sample_valid) begin
            if (count_after_pop_s == CW'(FIFO_DEPTH)) begin
                overflow_ev_s = 1'b1;
            end else begin
                push_ok_s = 1'b1;
            end
        end else begin
            push_ok_s     = 1'b0;
            overflow_ev_s = 1'b0;
        end
        count_next_s = count_after_pop_s + {{(CW-1){1'b0}}, push_ok_s};

        if (pop_ok_s) begin
            level_next_s = fifo_mem_r[rd_ptr_r];
        end else if (underrun_ev_s && !UNDERRUN_HOLD) begin
            level_next_s = 8'd128;
        end else begin
            level_next_s = level_r;
        end
    end

    // Sample storage; stale entries are harmless because pointers and count reset.
    always_ff @(posedge i_clk) begin
        if (push_ok_s) begin
            fifo_mem_r[wr_ptr_r] <= saturate9(i_sample);
        end
    end

    // Frame timing, FIFO bookkeeping, registered PWM and sticky flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            phase_r       <= 8'd0;
            started_r     <= 1'b0;
            wr_ptr_r      <= {PW{1'b0}};
            rd_ptr_r      <= {PW{1'b0}};
            count_r       <= {CW{1'b0}};
            level_r       <= 8'd0;
            pwm_r         <= 1'b0;
            frame_start_r <= 1'b0;
            overflow_r    <= 1'b0;
            underrun_r    <= 1'b0;
        end else begin
            phase_r       <= phase_next_s;
            started_r     <= 1'b1;
            count_r       <= count_next_s;
            level_r       <= level_next_s;
            pwm_r         <= (phase_next_s < level_next_s);
            frame_start_r <= (phase_next_s == 8'd0);
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            end
            if (overflow_ev_s) begin
                overflow_r <= 1'b1;
            end
            if (underrun_ev_s) begin
                underrun_r <= 1'b1;
            end
        end
    end

`ifdef AUDIO_PWM_SINK_STATS_EN
    logic [7:0] underrun_cnt_r;

    // Saturating underrun statistics counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            underrun_cnt_r <= 8'd0;
        end else if (underrun_ev_s && (underrun_cnt_r != 8'hFF)) begin
            underrun_cnt_r <= underrun_cnt_r + 8'd1;
        end
    end

    assign o_underrun_count = underrun_cnt_r;
`else
    assign o_underrun_count = 8'd0;
`endif

    assign o_pwm         = pwm_r;
    assign o_level       = level_r;
    assign o_frame_start = frame_start_r;
    assign o_fifo_count  = count_r;
    assign o_overflow    = overflow_r;
    assign o_underrun    = underrun_r;

endmodule

// File: doc/audio_pwm_sink.md
# audio_pwm_sink

Consumes the audio sample stream from the channel pipeline (`o_sample_valid` / 9-bit `o_sample`) and renders it as a single-bit PWM output for a board pin or RC filter. A small FIFO decouples the producer's sample-valid strobes from the fixed 256-cycle PWM frame. One sample is dequeued at each frame boundary, saturated to 8 bits, and held as the duty cycle for the whole frame. Underrun and overflow are flagged.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: sample FIFO entries; must be a power of two, 2..16.
- `UNDERRUN_HOLD`, default 1: on underrun, 1 repeats the previous duty and 0 loads midscale (128).

Ports:
- `i_clk` in 1: single clock.
- `i_rst` in 1: synchronous, active-high reset.
- `i_sample_valid` in 1: one-cycle strobe; `i_sample` is valid.
- `i_sample` in 9: unsigned sample from the channel.
- `o_pwm` out 1: registered PWM output.
- `o_level` out 8: duty of the current frame.
- `o_frame_start` out 1: one-cycle pulse in cycle 0 of each frame.
- `o_fifo_count` out $clog2(FIFO_DEPTH)+1: current occupancy.
- `o_overflow` out 1: sticky; a sample was dropped on a full FIFO.
- `o_underrun` out 1: sticky; a frame boundary found the FIFO empty.
- `o_underrun_count` out 8: saturating count of underruns; see Configuration.

## Operation
- **Frame counter.** `r_phase` is 8 bits and counts 0..255, then wraps to 0 every cycle. A frame is 256 cycles.
- **PWM output.** In the cycle where `r_phase == k`, `o_pwm` = (k < `o_level`).
  - Duty 0 gives a constant low.
  - Duty 255 gives high for 255 of 256 cycles.
- **Push.**
  - When `i_sample_valid` is high, the sample is saturated: if `i_sample[8]` = 1 the value becomes 255, otherwise `i_sample[7:0]`.
  - The saturated value is written to the FIFO tail, unless the FIFO is full after any same-cycle pop.
  - If the FIFO is still full, the sample is dropped and `o_overflow` is set.
- **Pop.** In the cycle where `r_phase == 255`:
  - If the FIFO is non-empty, the head is popped and becomes `o_level` at `r_phase == 0`.
  - If the FIFO is empty, the underrun response applies: `o_underrun` is set, and `o_level` keeps its value (`UNDERRUN_HOLD`=1) or becomes 128 (`UNDERRUN_HOLD`=0).
- **Simultaneous push and pop.**
  - The pop is evaluated first, so a push to a full FIFO in the pop cycle succeeds and the count is unchanged.
  - A push to an empty FIFO in the pop cycle does not satisfy that pop: it is an underrun, and the pushed sample is stored (count becomes 1).
- **FIFO.** Pointers are `$clog2(FIFO_DEPTH)` bits and wrap modulo depth. The count is tracked separately, so full and empty are unambiguous.
- **Sticky flags.** `o_overflow` and `o_underrun` clear only on `i_rst`.

## Timing
- **Reset values.** `o_pwm`=0, `o_level`=0, `o_frame_start`=0, `o_fifo_count`=0, `o_overflow`=0, `o_underrun`=0, `o_underrun_count`=0. Internally, `r_phase`=0 and both FIFO pointers are 0.
- **First cycle after reset release.**
  - `r_phase` = 0 and `o_frame_start`=1.
  - The first pop opportunity is 255 cycles later.
- **Push latency.** `o_fifo_count` updates the cycle after the strobe.
- **Sample-to-output latency.** A sample pushed into an empty FIFO at phase p drives `o_pwm` from the next phase-0 cycle, i.e. after (256 − p) cycles. A push exactly at p = 255 misses that boundary and waits a full frame.
- **Pop timing.** `o_level` and `o_frame_start` update on the same edge as the `r_phase` 255→0 wrap.
- **Reset mid-frame.**
  - Frame is aborted and FIFO contents are discarded.
  - All outputs return to their reset values on the next edge.
- **Producer rate.** Strobes are not rate-limited. Any producer sustaining more than one sample per 256 cycles eventually sets `o_overflow`.

## Configuration
- **Macro:** `AUDIO_PWM_SINK_STATS_EN`.
- **Defined:**
  - `o_underrun_count` increments on every underrun and saturates at 255.
  - It is cleared by `i_rst`.
- **Undefined:**
  - `o_underrun_count` is tied to 0 and no counter logic is synthesized.
  - `o_underrun` behaves identically in both builds.

## Test plan
- **Basic frame.** Reset, push 9'd64 at phase 10 → `o_fifo_count`=1 next cycle. From the next phase 0, `o_pwm` is high for exactly 64 cycles then low for 192; `o_level`=64.
- **Saturation.** Push 9'd300 → `o_level`=255 next frame; `o_pwm` is low only at phase 255. Push 9'd0 → `o_pwm` is constant low for that frame.
- **Overflow.** With `FIFO_DEPTH`=4, push 5 samples within phases 1..5 → `o_fifo_count`=4 and `o_overflow`=1. The dequeue order over the next 4 frames is samples 1–4.
- **Push-on-full at pop.** FIFO full, push at phase 255 → accepted, count stays 4, `o_overflow` stays 0.
- **Underrun.**
  - No pushes after one sample of 200 → the following frame keeps `o_level`=200 (`UNDERRUN_HOLD`=1), or becomes 128 (`UNDERRUN_HOLD`=0).
  - `o_underrun`=1 in both cases.
  - `o_underrun_count` increments per frame with `AUDIO_PWM_SINK_STATS_EN` defined and saturates at 255 after 300 empty frames; without the macro it reads 0.
- **Reset mid-frame.** Two samples queued, `i_rst` asserted at phase 100 → next cycle all outputs are at reset values, count 0. After release, the next pop is an underrun.
